// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: sequencing requests in from the hazard unit and
// execute stage, program counter and status out to instruction memory.
interface pc_fetch_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
);

  logic                     trigger;
  logic                     stall_req;
  logic                     branch_taken;
  logic [ADDRESS_WIDTH-1:0] branch_target;
  logic                     halt_req;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pcplus4;
  logic                     fetch_valid;
  logic                     flush_fd;
  logic [1:0]               state;
  logic                     stall_timeout;
  logic                     err_misalign;

  // Requester side: drives requests, observes PC and status
  modport master (
    output trigger, stall_req, branch_taken, branch_target, halt_req,
    input  pc, pcplus4, fetch_valid, flush_fd, state, stall_timeout, err_misalign
  );

  // Sequencer side: owns the PC and status
  modport slave (
    input  trigger, stall_req, branch_taken, branch_target, halt_req,
    output pc, pcplus4, fetch_valid, flush_fd, state, stall_timeout, err_misalign
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC sequencer: idle until started, advance by 4, hold on stalls,
// redirect and flush on taken branches, halt on requests or error conditions.
module pc_fetch_ctrl #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int unsigned              MAX_STALL     = 15
) (
  input logic              clk,
  input logic              rst,
  pc_fetch_ctrl_if.slave   bus
);

  // Wide enough to hold MAX_STALL; never narrower than one bit
  localparam int unsigned CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;
  logic                     misalign_q, misalign_d;

  logic [ADDRESS_WIDTH-1:0] pc_inc;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     stall_accept;
  logic                     flush;
  logic                     fetch;

  // Sequential PC increment wraps naturally at the address width
  assign pc_inc  = pc_q + ADDRESS_WIDTH'(4);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // A stall only wins when no halt or redirect outranks it
  assign stall_accept = bus.stall_req && !bus.halt_req && !bus.branch_taken;

  // Register stage: state, PC, stall counter and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state decision with halt > redirect > stall > advance priority
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    misalign_d = misalign_q;
    flush      = 1'b0;
    fetch      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.trigger) begin
          state_d = RUN;
        end
      end

      RUN, STALL: begin
        fetch = (state_q == RUN) && !stall_accept;
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (bus.branch_taken) begin
          flush = 1'b1;
          if (bus.branch_target[1:0] == 2'b00) begin
            pc_d    = bus.branch_target;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end
        end else if (bus.stall_req) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_STALL)) begin
            timeout_d = 1'b1;
            state_d   = HALT;
          end else begin
            state_d = STALL;
          end
        end else begin
          pc_d    = pc_inc;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      HALT: begin
        if (bus.trigger) begin
          state_d = RUN;
          pc_d    = RESET_VECTOR;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drive the bundle
  assign bus.pc            = pc_q;
  assign bus.pcplus4       = pc_inc;
  assign bus.fetch_valid   = fetch;
  assign bus.flush_fd      = flush;
  assign bus.state         = state_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.err_misalign  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with hand-computed expectations.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pc_fetch_ctrl_if #(.ADDRESS_WIDTH(32)) bus ();

  pc_fetch_ctrl #(
    .ADDRESS_WIDTH(32),
    .RESET_VECTOR (32'h0000_0000),
    .MAX_STALL    (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.trigger       = 1'b0;
    bus.stall_req     = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.halt_req      = 1'b0;

    // 1. reset for two cycles, then start and run freely
    tick(); tick();
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);
    chk("rst_misalign", 32'(bus.err_misalign), 32'h0);
    rst = 1'b0;
    bus.stall_req = 1'b0;
    bus.trigger = 1'b1;
    settle();
    chk("idle_fetch", 32'(bus.fetch_valid), 32'h0);
    chk("idle_pc", bus.pc, 32'h0);
    tick();
    bus.trigger = 1'b0;
    settle();
    chk("run_state", 32'(bus.state), 32'h1);
    chk("run_pc0", bus.pc, 32'h0);
    chk("run_pcplus4_0", bus.pcplus4, 32'h4);
    chk("run_fetch", 32'(bus.fetch_valid), 32'h1);
    tick(); chk("run_pc4", bus.pc, 32'h4);
    chk("run_pcplus4_4", bus.pcplus4, 32'h8);
    tick(); chk("run_pc8", bus.pc, 32'h8);
    tick(); chk("run_pcc", bus.pc, 32'hC);
    tick(); chk("run_pc10", bus.pc, 32'h10);

    // 2. three stalled cycles, then a branch colliding with a stall
    bus.stall_req = 1'b1;
    settle();
    chk("stall_accept_fetch", 32'(bus.fetch_valid), 32'h0);
    chk("stall_accept_flush", 32'(bus.flush_fd), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("stall_state", 32'(bus.state), 32'h2);
      chk("stall_pc", bus.pc, 32'h10);
      chk("stall_fetch", 32'(bus.fetch_valid), 32'h0);
    end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    settle();
    chk("collide_flush", 32'(bus.flush_fd), 32'h1);
    tick();
    bus.branch_taken = 1'b0;
    bus.stall_req    = 1'b0;
    settle();
    chk("collide_pc", bus.pc, 32'h40);
    chk("collide_state", 32'(bus.state), 32'h1);
    chk("collide_flush_drop", 32'(bus.flush_fd), 32'h0);
    chk("collide_fetch", 32'(bus.fetch_valid), 32'h1);

    // 3. misaligned redirect, then restart from HALT
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h42;
    settle();
    chk("mis_flush", 32'(bus.flush_fd), 32'h1);
    tick();
    bus.branch_taken = 1'b0;
    settle();
    chk("mis_state", 32'(bus.state), 32'h3);
    chk("mis_pc", bus.pc, 32'h40);
    chk("mis_flag", 32'(bus.err_misalign), 32'h1);
    chk("halt_fetch", 32'(bus.fetch_valid), 32'h0);
    chk("halt_flush", 32'(bus.flush_fd), 32'h0);
    tick();
    chk("halt_hold_pc", bus.pc, 32'h40);
    bus.trigger = 1'b1;
    tick();
    chk("restart_state", 32'(bus.state), 32'h1);
    chk("restart_pc", bus.pc, 32'h0);
    chk("restart_mis_sticky", 32'(bus.err_misalign), 32'h1);
    tick();
    bus.trigger = 1'b0;
    chk("trigger_in_run_pc", bus.pc, 32'h4);
    chk("trigger_in_run_state", 32'(bus.state), 32'h1);

    // 4. stall held for 20 cycles: timeout after the 15th stalled cycle
    bus.stall_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("to_pc", bus.pc, 32'h4);
      if (i < 15) begin
        chk("to_state_stall", 32'(bus.state), 32'h2);
        chk("to_flag_clear", 32'(bus.stall_timeout), 32'h0);
      end else begin
        chk("to_state_halt", 32'(bus.state), 32'h3);
        chk("to_flag_set", 32'(bus.stall_timeout), 32'h1);
      end
    end
    bus.stall_req = 1'b0;
    bus.trigger   = 1'b1;
    tick();
    bus.trigger = 1'b0;
    chk("to_restart_pc", bus.pc, 32'h0);
    chk("to_restart_sticky", 32'(bus.stall_timeout), 32'h1);

    // 5. wrap-around, then halt outranks a simultaneous branch
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFF8;
    tick();
    bus.branch_taken = 1'b0;
    settle();
    chk("wrap_pc_f8", bus.pc, 32'hFFFF_FFF8);
    chk("wrap_plus4_f8", bus.pcplus4, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_fc", bus.pc, 32'hFFFF_FFFC);
    chk("wrap_plus4_fc", bus.pcplus4, 32'h0);
    tick();
    chk("wrap_pc_0", bus.pc, 32'h0);
    bus.halt_req      = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h80;
    settle();
    chk("halt_pri_flush", 32'(bus.flush_fd), 32'h0);
    tick();
    bus.halt_req     = 1'b0;
    bus.branch_taken = 1'b0;
    chk("halt_pri_state", 32'(bus.state), 32'h3);
    chk("halt_pri_pc", bus.pc, 32'h0);

    // 6. reset in the middle of a stall, then stall counting from zero
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    tick();
    chk("pre6_pc", bus.pc, 32'h4);
    bus.stall_req = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    chk("mid_stall_state", 32'(bus.state), 32'h2);
    rst = 1'b1;
    bus.trigger = 1'b1;
    tick();
    rst = 1'b0;
    bus.trigger = 1'b0;
    chk("rst2_state", 32'(bus.state), 32'h0);
    chk("rst2_pc", bus.pc, 32'h0);
    chk("rst2_timeout", 32'(bus.stall_timeout), 32'h0);
    chk("rst2_misalign", 32'(bus.err_misalign), 32'h0);
    tick();
    chk("rst2_idle_ignores_stall", 32'(bus.state), 32'h0);
    bus.stall_req = 1'b0;
    bus.trigger   = 1'b1;
    tick();
    bus.trigger   = 1'b0;
    bus.stall_req = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i < 15) begin
        chk("recount_state", 32'(bus.state), 32'h2);
        chk("recount_flag", 32'(bus.stall_timeout), 32'h0);
      end else begin
        chk("recount_halt", 32'(bus.state), 32'h3);
        chk("recount_flag_set", 32'(bus.stall_timeout), 32'h1);
      end
    end
    bus.stall_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch-side sequencer that owns the program counter and decides its next value every cycle. It holds the core in idle until started, advances PC by 4, and holds PC on hazard stalls. It redirects to branch/jump targets and flushes the fetch/decode stage, and halts on halt requests or error conditions. It sits between the hazard unit/execute-stage branch resolution and instruction memory, and replaces the free-running PC path.

Parameters:
ADDRESS_WIDTH, 32, width of PC and branch target
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset and on restart
MAX_STALL, 15, consecutive stall cycles tolerated before timeout; counter is clog2(MAX_STALL+1) bits wide

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
trigger  input  1  start pulse; starts from IDLE, restarts from HALT
stall_req  input  1  hazard unit request to hold PC
branch_taken  input  1  execute stage resolved taken branch/jump (pcsrc)
branch_target  input  ADDRESS_WIDTH  redirect address, valid when branch_taken=1
halt_req  input  1  ecall/ebreak/end-of-program halt
pc  output  ADDRESS_WIDTH  registered current PC to instruction memory
pcplus4  output  ADDRESS_WIDTH  combinational pc+4, used by the result mux for jal/jalr
fetch_valid  output  1  combinational; 1 only when state=RUN and no stall is accepted this cycle
flush_fd  output  1  combinational; 1 in the cycle a redirect is accepted
state  output  2  IDLE=00, RUN=01, STALL=10, HALT=11
stall_timeout  output  1  sticky; set when the stall limit is hit
err_misalign  output  1  sticky; set when a redirect target is misaligned

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-stall or mid-redirect):
  - state=IDLE, pc=RESET_VECTOR, stall counter=0.
  - stall_timeout=0, err_misalign=0.
  - All inputs are ignored in that cycle.
- IDLE:
  - pc is held; fetch_valid=0; flush_fd=0.
  - trigger=1 -> RUN, pc is unchanged, so the first fetch is RESET_VECTOR.
  - All other inputs are ignored.
- RUN and STALL share this per-cycle priority, highest first:
  1. halt_req -> HALT; pc held.
  2. branch_taken with branch_target[1:0]==0:
     - pc <= branch_target; flush_fd=1; stall counter cleared; next state RUN.
     - A branch overrides a simultaneous stall_req.
  3. branch_taken with branch_target[1:0]!=0:
     - err_misalign <= 1; next state HALT; pc held; flush_fd=1.
  4. stall_req:
     - pc held; next state STALL; stall counter increments.
     - When the counter reaches MAX_STALL while stall_req is still high: stall_timeout <= 1, next state HALT.
  5. Otherwise (no request):
     - pc <= pc+4; next state RUN; stall counter cleared.
     - Arriving from STALL, pc+4 is applied in the same cycle stall_req drops.
- Counter and timeout behaviour:
  - The stall counter counts consecutive stalled cycles; MAX_STALL stalled cycles trigger the timeout.
  - A branch or any non-stall cycle clears the counter.
- HALT:
  - pc held; fetch_valid=0; flush_fd=0.
  - trigger=1 -> RUN with pc <= RESET_VECTOR and the stall counter cleared.
  - Sticky error flags are cleared only by rst.
- Arithmetic: pc+4 wraps modulo 2^ADDRESS_WIDTH (e.g. 32'hFFFF_FFFC -> 32'h0000_0000), with no flag.
- trigger is ignored in RUN and STALL.
- Latency: every decision takes effect on pc at the next rising edge. flush_fd and fetch_valid are same-cycle combinational.

Test Plan:
1. Reset then trigger, 4 free cycles: rst=1 for 2 cycles, then trigger pulse -> state 00->01; pc sequence 0x0,0x0,0x4,0x8,0xC; pcplus4 = pc+4 every cycle; fetch_valid=1 in RUN.
2. Stall then branch collision: at pc=0x10, stall_req=1 for 3 cycles -> pc held at 0x10, state=10, fetch_valid=0. Next, stall_req=1 with branch_taken=1 and target 0x40 -> pc=0x40 next cycle, flush_fd=1 for exactly that cycle, state=01.
3. Misaligned redirect: branch_taken=1 with target 0x42 -> err_misalign=1, state=11, pc unchanged. trigger -> pc=RESET_VECTOR, state=01, err_misalign stays 1.
4. Stall timeout: MAX_STALL=15, stall_req held 20 cycles -> stall_timeout=1 after the 15th stalled cycle, state=11, pc frozen.
5. Wrap and halt priority: force pc to 0xFFFF_FFF8 via a branch -> next pcs 0xFFFF_FFFC, then 0x0000_0000. Then halt_req=1 with branch_taken=1 simultaneously -> HALT, pc not redirected.
6. Reset mid-stall: in STALL with counter=7, assert rst -> state=00, pc=RESET_VECTOR, counter=0, flags=0. Stall counting restarts from zero after a new trigger.
